// File: rtl/surf_sysref_checker.sv
// SYSREF alignment checker: measures the aclk offset from the local sync pulse to the
// SYSREF rising edge, declares lock after a run of identical offsets, flags mismatches/misses.
module surf_sysref_checker #(
    parameter int unsigned SYNC_PERIOD = 48,
    parameter int unsigned LOCK_COUNT  = 8,
    parameter int unsigned MISS_LIMIT  = 4
) (
    input  logic        aclk_i,
    input  logic        aclk_rst_i,
    input  logic        enable_i,
    input  logic        clear_i,
    input  logic        sync_i,
    input  logic        sysref_i,
    output logic [5:0]  offset_o,
    output logic        offset_valid_o,
    output logic        locked_o,
    output logic [15:0] err_count_o,
    output logic        miss_o
);

    localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0] LOCK_VAL  = MW'(LOCK_COUNT);
    localparam logic [2:0]    MISS_LAST = 3'(MISS_LIMIT - 1);

    if (SYNC_PERIOD < 2 || SYNC_PERIOD > 63 || MISS_LIMIT < 1 || MISS_LIMIT > 7) begin : g_bad_param
        $error("SYNC_PERIOD must fit the 6-bit phase counter and MISS_LIMIT the 3-bit period counter");
    end

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SYNC,
        ACQUIRE,
        TRACK
    } state_t;

    state_t          state, state_nxt;
    logic            sysref_q;
    logic [5:0]      phase_cnt;
    logic [2:0]      period_cnt, period_nxt;
    logic [5:0]      ref_offset, ref_nxt;
    logic [MW-1:0]   match_cnt, match_nxt;
    logic [5:0]      offset_nxt;
    logic            valid_nxt, locked_nxt, miss_nxt;
    logic [15:0]     err_nxt;

    logic            sysref_edge;
    logic            phase_sat;
    logic [5:0]      meas;

    assign sysref_edge = sysref_i & ~sysref_q;
    // A saturated phase counter means no sync for 63+ cycles: the offset is meaningless.
    assign phase_sat   = ~sync_i & (phase_cnt == 6'd63);
    assign meas        = sync_i ? 6'd0 : phase_cnt;

    always_comb begin
        state_nxt  = state;
        period_nxt = period_cnt;
        ref_nxt    = ref_offset;
        match_nxt  = match_cnt;
        offset_nxt = offset_o;
        valid_nxt  = offset_valid_o;
        locked_nxt = locked_o;
        err_nxt    = err_count_o;
        miss_nxt   = miss_o;

        if (clear_i || !enable_i) begin
            err_nxt    = '0;
            miss_nxt   = 1'b0;
            locked_nxt = 1'b0;
            valid_nxt  = 1'b0;
            match_nxt  = '0;
            period_nxt = '0;
            state_nxt  = enable_i ? WAIT_SYNC : IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = WAIT_SYNC;
                WAIT_SYNC: begin
                    if (sync_i) state_nxt = ACQUIRE;
                end
                ACQUIRE: begin
                    if (sysref_edge) begin
                        offset_nxt = meas;
                        valid_nxt  = 1'b1;
                        ref_nxt    = meas;
                        match_nxt  = MW'(1);
                        state_nxt  = TRACK;
                    end
                end
                TRACK: begin
                    if (sysref_edge) begin
                        offset_nxt = meas;
                        if (!phase_sat && meas == ref_offset) begin
                            if (match_cnt != LOCK_VAL) match_nxt = match_cnt + 1'b1;
                            locked_nxt = (match_nxt == LOCK_VAL);
                        end else begin
                            if (err_count_o != '1) err_nxt = err_count_o + 1'b1;
                            ref_nxt    = meas;
                            match_nxt  = MW'(1);
                            locked_nxt = 1'b0;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase

            // The edge resets the period count and wins over a coincident sync.
            if (state == ACQUIRE || state == TRACK) begin
                if (sysref_edge) begin
                    period_nxt = '0;
                end else if (sync_i) begin
                    if (period_cnt != '1) period_nxt = period_cnt + 1'b1;
                    if (period_cnt == MISS_LAST) begin
                        miss_nxt   = 1'b1;
                        locked_nxt = 1'b0;
                        match_nxt  = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge aclk_i) begin
        if (aclk_rst_i) begin
            state          <= IDLE;
            sysref_q       <= 1'b0;
            phase_cnt      <= '0;
            period_cnt     <= '0;
            ref_offset     <= '0;
            match_cnt      <= '0;
            offset_o       <= '0;
            offset_valid_o <= 1'b0;
            locked_o       <= 1'b0;
            err_count_o    <= '0;
            miss_o         <= 1'b0;
        end else begin
            state          <= state_nxt;
            sysref_q       <= sysref_i;
            if (sync_i)
                phase_cnt <= 6'd1;
            else if (phase_cnt != 6'd63)
                phase_cnt <= phase_cnt + 1'b1;
            period_cnt     <= period_nxt;
            ref_offset     <= ref_nxt;
            match_cnt      <= match_nxt;
            offset_o       <= offset_nxt;
            offset_valid_o <= valid_nxt;
            locked_o       <= locked_nxt;
            err_count_o    <= err_nxt;
            miss_o         <= miss_nxt;
        end
    end

endmodule

// File: doc/surf_sysref_checker.md
# surf_sysref_checker

Verifies, in the aclk domain, that the PL SYSREF lands at a fixed, repeatable aclk offset relative to the locally generated sync pulse. It sits directly downstream of the sync generator, consuming its one-cycle aclk `sync` output together with the synchronized PL SYSREF level. It measures the sync-to-SYSREF offset, declares lock after a run of identical measurements, and counts mismatches and missing SYSREFs. This is a power-on alignment check; results are read out over the register interface.

## Interface
Parameters:
- `SYNC_PERIOD`, 48: aclk cycles per sync period (16 ifclk cycles × 3).
- `LOCK_COUNT`, 8: consecutive identical offsets required to assert lock.
- `MISS_LIMIT`, 4: sync periods without a SYSREF rising edge before a miss is declared.

Ports:
- `aclk_i`, in, 1: sole clock, 375 MHz.
- `aclk_rst_i`, in, 1: reset, synchronous, active-high.
- `enable_i`, in, 1: run the checker; a low level returns the block to IDLE.
- `clear_i`, in, 1: one-cycle pulse; clears counters and restarts acquisition.
- `sync_i`, in, 1: one-cycle aclk sync pulse from the sync generator.
- `sysref_i`, in, 1: PL SYSREF level, already synchronized to aclk.
- `offset_o`, out, 6: most recent measured offset, in aclk cycles.
- `offset_valid_o`, out, 1: at least one offset has been captured since acquisition began.
- `locked_o`, out, 1: the last `LOCK_COUNT` offsets were identical.
- `err_count_o`, out, 16: offset mismatches while in TRACK; saturating.
- `miss_o`, out, 1: sticky; set when no SYSREF edge is seen for `MISS_LIMIT` sync periods.

## Operation
- Edge detect:
  - `sysref_q` holds `sysref_i` delayed by one aclk cycle.
  - A SYSREF edge occurs when `sysref_i` is 1 and `sysref_q` is 0.
- Phase counter `phase_cnt` (6 bits):
  - Loads 1 on `sync_i`.
  - Otherwise increments, saturating at 63.
  - The measured offset is 0 if `sync_i` and the edge occur in the same cycle; otherwise it is `phase_cnt`.
- Period counter: counts `sync_i` pulses since the last SYSREF edge; saturating, 3 bits.
- States:
  - IDLE: outputs held; leaves to WAIT_SYNC when `enable_i` is 1.
  - WAIT_SYNC: SYSREF edges are ignored; moves to ACQUIRE on the first `sync_i`.
  - ACQUIRE: on a SYSREF edge:
    - `offset_o` takes the measured offset and `offset_valid_o` is set.
    - The reference offset is set to the measured offset.
    - The match count is set to 1.
    - The state moves to TRACK.
  - TRACK, on a SYSREF edge whose offset equals the reference:
    - The match count increments, saturating at `LOCK_COUNT`.
    - `locked_o` is 1 once the count equals `LOCK_COUNT`.
  - TRACK, on a SYSREF edge whose offset differs from the reference:
    - `err_count_o` increments, saturating at 0xFFFF.
    - The reference is set to the new offset and the match count is set to 1.
    - `locked_o` is cleared.
    - The state stays TRACK.
  - `offset_o` updates on every edge in ACQUIRE and TRACK.
- Miss detection (ACQUIRE or TRACK):
  - If the period counter reaches `MISS_LIMIT` without a SYSREF edge, `miss_o` is set (sticky), `locked_o` is cleared and the match count is set to 0.
  - The state does not change.
- A SYSREF edge when `phase_cnt` is 63 (no sync for 63 or more cycles):
  - Treated as a mismatch in TRACK.
  - Captured normally in ACQUIRE.
- `clear_i`, or `enable_i` going low:
  - Clears `err_count_o`, `miss_o`, `locked_o`, `offset_valid_o`, the match count and the period counter.
  - The state becomes WAIT_SYNC if `enable_i` is 1, else IDLE.
  - `offset_o` retains its value.
  - `clear_i` has priority over a simultaneous SYSREF edge, which is dropped.

## Timing
- Reset values:
  - State is IDLE.
  - All outputs are 0.
  - `phase_cnt`, `sysref_q`, reference, match count and period counter are 0.
- Latency: outputs update on the aclk edge after the cycle in which the SYSREF edge is detected (one cycle after `sysref_i` rises).
- `sync_i` and a SYSREF edge in the same cycle:
  - The offset is 0.
  - The period counter resets due to the edge; the edge takes precedence over the increment.
- `locked_o` rises in the cycle after the `LOCK_COUNT`-th matching edge is registered.
- `miss_o` rises one cycle after the `MISS_LIMIT`-th `sync_i` with no intervening edge.
- Reset asserted mid-operation returns everything to the reset values on the next aclk edge, regardless of `clear_i` or `enable_i`.

## Test plan
- **Steady lock:** enable; `sync_i` every 48 cycles; SYSREF rises 5 cycles after each `sync_i`, 10 periods → `offset_o`=5, `offset_valid_o`=1 after the first edge, `locked_o`=1 after the 8th edge, `err_count_o`=0.
- **Coincident edge:** SYSREF rises in the same cycle as `sync_i` → `offset_o`=0; lock after 8 periods.
- **Phase slip:** after lock at offset 5, one SYSREF arrives at offset 6, then at 6 thereafter → `err_count_o`=1, `locked_o` drops the cycle after the mismatch and re-asserts after 8 edges at 6.
- **Missing SYSREF:** after lock, stop SYSREF for 4 sync periods → `miss_o`=1 and `locked_o`=0 one cycle after the 4th `sync_i`; `miss_o` stays set when SYSREF resumes.
- **Pre-sync edges:** SYSREF edges before any `sync_i` → ignored (`offset_valid_o`=0); the first edge after sync is captured.
- **Clear and reset priority:** `clear_i` in the same cycle as a SYSREF edge → edge dropped, counters 0, state WAIT_SYNC. Reset asserted in TRACK → all outputs 0 next cycle.
